// File: rtl/onehot_utility.sv
`default_nettype none
// ============================================================================
// Module      : onehot_utility
// Description : Converts a one-hot vector into its binary index. The lowest
//               set bit wins on multi-hot input. Provides a combinational
//               index/zero result and a registered copy with valid and flags.
//               Optional macro ONEHOT_UTILITY_CHECK_EN builds the multi-hot
//               detector behind err_multi / err_seen; otherwise both tie to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_utility #(
    parameter  int N = 32,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] onehot_in,
    input  logic         in_valid,
    output logic [W-1:0] bin_comb,
    output logic         zero_comb,
    output logic [W-1:0] bin_q,
    output logic         zero_q,
    output logic         out_valid,
    output logic         err_multi,
    output logic         err_seen
);

    logic [W-1:0] w_bin;
    logic         w_zero;
    logic [W-1:0] r_bin;
    logic         r_zero;
    logic         r_valid;

    // Priority encoder: scan from the top so the lowest set bit is written last
    always_comb begin
        w_bin = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (onehot_in[i]) begin
                w_bin = W'(i);
            end
        end
    end

    assign w_zero    = ~|onehot_in;
    assign bin_comb  = w_bin;
    assign zero_comb = w_zero;

    // Capture index and zero flag when the input is qualified; valid follows in_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin   <= '0;
            r_zero  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_bin  <= w_bin;
                r_zero <= w_zero;
            end
        end
    end

    assign bin_q     = r_bin;
    assign zero_q    = r_zero;
    assign out_valid = r_valid;

`ifdef ONEHOT_UTILITY_CHECK_EN
    logic w_multi;
    logic r_err_multi;
    logic r_err_seen;

    // Clearing the lowest set bit leaves something behind only if two or more were set
    assign w_multi = (onehot_in & (onehot_in - N'(1))) != '0;

    // Per-capture multi-hot flag plus a sticky copy that only reset clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_multi <= 1'b0;
            r_err_seen  <= 1'b0;
        end else begin
            r_err_multi <= in_valid & w_multi;
            if (in_valid & w_multi) begin
                r_err_seen <= 1'b1;
            end
        end
    end

    assign err_multi = r_err_multi;
    assign err_seen  = r_err_seen;
`else
    assign err_multi = 1'b0;
    assign err_seen  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_onehot_utility.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_utility
// Description : Self-checking bench for onehot_utility at N=8, N=32 and N=1.
//               A behavioural model is compared on every falling edge, and
//               directed vectors carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_utility;

`ifdef ONEHOT_UTILITY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        r_reset = 1'b0;
    logic [7:0]  r_a8 = '0;
    logic        r_v8 = 1'b0;
    logic [31:0] r_a32 = '0;
    logic        r_v32 = 1'b0;
    logic [0:0]  r_a1 = '0;
    logic        r_v1 = 1'b0;

    logic [2:0] w_bc8, w_bq8;
    logic [4:0] w_bc32, w_bq32;
    logic [0:0] w_bc1, w_bq1;
    logic w_zc8, w_zq8, w_ov8, w_em8, w_es8;
    logic w_zc32, w_zq32, w_ov32, w_em32, w_es32;
    logic w_zc1, w_zq1, w_ov1, w_em1, w_es1;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    onehot_utility #(.N(8)) u_dut8 (
        .clk(clk), .reset(r_reset), .onehot_in(r_a8), .in_valid(r_v8),
        .bin_comb(w_bc8), .zero_comb(w_zc8), .bin_q(w_bq8), .zero_q(w_zq8),
        .out_valid(w_ov8), .err_multi(w_em8), .err_seen(w_es8)
    );

    onehot_utility #(.N(32)) u_dut32 (
        .clk(clk), .reset(r_reset), .onehot_in(r_a32), .in_valid(r_v32),
        .bin_comb(w_bc32), .zero_comb(w_zc32), .bin_q(w_bq32), .zero_q(w_zq32),
        .out_valid(w_ov32), .err_multi(w_em32), .err_seen(w_es32)
    );

    onehot_utility #(.N(1)) u_dut1 (
        .clk(clk), .reset(r_reset), .onehot_in(r_a1), .in_valid(r_v1),
        .bin_comb(w_bc1), .zero_comb(w_zc1), .bin_q(w_bq1), .zero_q(w_zq1),
        .out_valid(w_ov1), .err_multi(w_em1), .err_seen(w_es1)
    );

    // Inputs and outputs gathered per instance: 0 = N8, 1 = N32, 2 = N1
    logic [31:0] w_x[3];
    logic        w_v[3];
    logic [31:0] w_bc[3], w_bq[3];
    logic        w_zc[3], w_zq[3], w_ov[3], w_em[3], w_es[3];
    string       c_tag[3] = '{"n8", "n32", "n1"};

    assign w_x[0] = {24'd0, r_a8};
    assign w_x[1] = r_a32;
    assign w_x[2] = {31'd0, r_a1};
    assign w_v[0] = r_v8;
    assign w_v[1] = r_v32;
    assign w_v[2] = r_v1;
    assign w_bc[0] = 32'(w_bc8);
    assign w_bc[1] = 32'(w_bc32);
    assign w_bc[2] = 32'(w_bc1);
    assign w_bq[0] = 32'(w_bq8);
    assign w_bq[1] = 32'(w_bq32);
    assign w_bq[2] = 32'(w_bq1);
    assign w_zc[0] = w_zc8;  assign w_zc[1] = w_zc32;  assign w_zc[2] = w_zc1;
    assign w_zq[0] = w_zq8;  assign w_zq[1] = w_zq32;  assign w_zq[2] = w_zq1;
    assign w_ov[0] = w_ov8;  assign w_ov[1] = w_ov32;  assign w_ov[2] = w_ov1;
    assign w_em[0] = w_em8;  assign w_em[1] = w_em32;  assign w_em[2] = w_em1;
    assign w_es[0] = w_es8;  assign w_es[1] = w_es32;  assign w_es[2] = w_es1;

    // Index of the lowest set bit: isolate it with two's complement, then locate it
    function automatic int lowest(input logic [31:0] x);
        logic [31:0] iso;
        lowest = 0;
        iso = x & (~x + 32'd1);
        for (int i = 0; i < 32; i++) begin
            if (iso == (32'd1 << i)) lowest = i;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model of the registered outputs
    int m_bin[3];
    bit m_zero[3], m_val[3], m_err[3], m_seen[3];

    always @(posedge clk or posedge r_reset) begin
        if (r_reset) begin
            for (int k = 0; k < 3; k++) begin
                m_bin[k]  <= 0;
                m_zero[k] <= 1'b1;
                m_val[k]  <= 1'b0;
                m_err[k]  <= 1'b0;
                m_seen[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_val[k] <= w_v[k];
                m_err[k] <= CHK && w_v[k] && ($countones(w_x[k]) > 1);
                if (w_v[k]) begin
                    m_bin[k]  <= lowest(w_x[k]);
                    m_zero[k] <= (w_x[k] == 32'd0);
                    if (CHK && $countones(w_x[k]) > 1) m_seen[k] <= 1'b1;
                end
            end
        end
    end

    // Compare every output of every instance against the model each falling edge
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk({c_tag[k], "_bin_comb"},  w_bc[k], 32'(lowest(w_x[k])));
            chk({c_tag[k], "_zero_comb"}, 32'(w_zc[k]), 32'(w_x[k] == 32'd0));
            chk({c_tag[k], "_bin_q"},     w_bq[k], 32'(m_bin[k]));
            chk({c_tag[k], "_zero_q"},    32'(w_zq[k]), 32'(m_zero[k]));
            chk({c_tag[k], "_out_valid"}, 32'(w_ov[k]), 32'(m_val[k]));
            chk({c_tag[k], "_err_multi"}, 32'(w_em[k]), 32'(m_err[k]));
            chk({c_tag[k], "_err_seen"},  32'(w_es[k]), 32'(m_seen[k]));
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 r_reset = 1'b1;
        #12;
        chk("rst_bin_q", 32'(w_bq8), 32'd0);
        chk("rst_zero_q", 32'(w_zq8), 32'd1);
        chk("rst_out_valid", 32'(w_ov8), 32'd0);
        chk("rst_err_seen", 32'(w_es8), 32'd0);
        next_cycle();
        r_reset = 1'b0;

        // Single one-hot bit
        next_cycle();
        r_a8 = 8'b0000_0100; r_v8 = 1'b1;
        #1;
        chk("oh4_bin_comb", 32'(w_bc8), 32'd2);
        chk("oh4_zero_comb", 32'(w_zc8), 32'd0);
        next_cycle();
        chk("oh4_bin_q", 32'(w_bq8), 32'd2);
        chk("oh4_zero_q", 32'(w_zq8), 32'd0);
        chk("oh4_out_valid", 32'(w_ov8), 32'd1);

        // All-zero input
        r_a8 = 8'd0; r_v8 = 1'b1;
        #1;
        chk("zero_bin_comb", 32'(w_bc8), 32'd0);
        chk("zero_zero_comb", 32'(w_zc8), 32'd1);
        next_cycle();
        chk("zero_bin_q", 32'(w_bq8), 32'd0);
        chk("zero_zero_q", 32'(w_zq8), 32'd1);
        chk("zero_out_valid", 32'(w_ov8), 32'd1);
        chk("zero_err_multi", 32'(w_em8), 32'd0);

        // Multi-hot resolves to the lowest set bit
        r_a8 = 8'b1010_0000; r_v8 = 1'b1;
        #1;
        chk("multi_bin_comb", 32'(w_bc8), 32'd5);
        next_cycle();
        chk("multi_err_multi", 32'(w_em8), 32'(CHK));
        chk("multi_err_seen", 32'(w_es8), 32'(CHK));
        r_v8 = 1'b0; r_a8 = 8'b0000_0001;
        next_cycle();
        chk("idle_err_multi", 32'(w_em8), 32'd0);
        chk("idle_err_seen", 32'(w_es8), 32'(CHK));
        chk("idle_out_valid", 32'(w_ov8), 32'd0);
        chk("idle_bin_q_hold", 32'(w_bq8), 32'd5);

        // Load bin_q=5 then reset between edges
        r_a8 = 8'b0010_0000; r_v8 = 1'b1;
        next_cycle();
        chk("pre_rst_bin_q", 32'(w_bq8), 32'd5);
        chk("pre_rst_out_valid", 32'(w_ov8), 32'd1);
        #2 r_reset = 1'b1;
        #1;
        chk("mid_rst_bin_q", 32'(w_bq8), 32'd0);
        chk("mid_rst_zero_q", 32'(w_zq8), 32'd1);
        chk("mid_rst_out_valid", 32'(w_ov8), 32'd0);
        chk("mid_rst_err_seen", 32'(w_es8), 32'd0);
        @(negedge clk);
        #1;
        r_reset = 1'b0;
        r_a8 = 8'b0000_0010; r_v8 = 1'b1;
        next_cycle();
        chk("post_rst_bin_q", 32'(w_bq8), 32'd1);

        // Walk a single one through the 32-bit instance
        r_v8 = 1'b0;
        r_v32 = 1'b1;
        for (int k = 0; k < 32; k++) begin
            r_a32 = 32'd1 << k;
            #1;
            chk("walk_bin_comb", 32'(w_bc32), 32'(k));
            next_cycle();
        end
        chk("walk_last_bin_q", 32'(w_bq32), 32'd31);
        r_a32 = 32'hFFFF_0000;
        #1;
        chk("wide_multi_bin_comb", 32'(w_bc32), 32'd16);
        next_cycle();
        r_a32 = 32'hFFFF_FFFF;
        next_cycle();
        r_v32 = 1'b0;

        // Single-bit instance
        r_a1 = 1'b1; r_v1 = 1'b1;
        #1;
        chk("n1_one_bin_comb", 32'(w_bc1), 32'd0);
        chk("n1_one_zero_comb", 32'(w_zc1), 32'd0);
        next_cycle();
        r_a1 = 1'b0;
        #1;
        chk("n1_zero_zero_comb", 32'(w_zc1), 32'd1);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
